// File: rtl/neuron_layer_pkg.sv
// Shared definitions for the neuron_layer block.
//  - FSM state encoding (NL_IDLE / NL_RUN / NL_OUT)
//  - default fixed-point format (Q8.8 in 16 bits)
//  - weight RAM layout: each neuron owns an 8-word slot, 7 weights then the bias
package neuron_layer_pkg;

  localparam int NL_DATA_W = 16;
  localparam int NL_FRAC   = 8;
  localparam int NL_STRIDE = 8;   // weight RAM words per neuron
  localparam int NL_TERMS  = 7;   // input vector length
  localparam int NL_LAST_K = 8;   // RUN cycles are k = 0..NL_LAST_K

  typedef enum logic [1:0] {
    NL_IDLE = 2'd0,
    NL_RUN  = 2'd1,
    NL_OUT  = 2'd2
  } nl_state_e;

endpackage

// File: rtl/neuron_mac.sv
// Signed multiply-accumulate for one neuron at a time.
//  clk_i    clock, rising edge
//  rst_ni   synchronous active-low reset, clears the accumulator
//  clr_i    clear the accumulator (wins over acc_i/bias_i)
//  acc_i    acc += w_i * x_i
//  bias_i   acc += w_i <<< FRAC (bias aligned to product scale)
//  w_i/x_i  signed operands
//  res_o    relu(saturate(acc >>> FRAC)), combinational
module neuron_mac
  import neuron_layer_pkg::*;
#(
  parameter int DATA_W = NL_DATA_W,
  parameter int FRAC   = NL_FRAC
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              acc_i,
  input  logic              bias_i,
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] x_i,
  output logic [DATA_W-1:0] res_o
);

  // 4 guard bits: 8 terms of full-width products cannot overflow
  localparam int ACC_W = 2*DATA_W + 4;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, shr;
  logic        [DATA_W-1:0]   sat;

  assign prod     = $signed(w_i) * $signed(x_i);
  assign prod_ext = {{4{prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W){w_i[DATA_W-1]}}, w_i} <<< FRAC;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)       acc_d = '0;
    else if (acc_i)  acc_d = acc_q + prod_ext;
    else if (bias_i) acc_d = acc_q + bias_ext;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign shr = acc_q >>> FRAC;

  always_comb begin
    if (shr > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (shr < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                    sat = shr[DATA_W-1:0];
    res_o = sat[DATA_W-1] ? '0 : sat;
  end

endmodule

// File: rtl/neuron_layer.sv
// One fully-connected ANN layer evaluated on a single time-shared MAC.
//  clk/reset             clock, synchronous active-low reset
//  data_in_0..6, in_rdy  input vector and its one-cycle valid pulse
//  w_addr/w_rd/w_data    synchronous weight RAM port (data one cycle after address)
//  out_data/out_idx      ReLU result and neuron index, held between pulses
//  out_valid/out_last    result strobe, last-neuron flag
//  busy                  evaluation in progress
//  in_drop               in_rdy arrived while busy and was ignored
// Each neuron takes 10 cycles: 9 RUN cycles (8 reads, accumulate lags a cycle) + 1 OUT.
module neuron_layer
  import neuron_layer_pkg::*;
#(
  parameter int DATA_W      = NL_DATA_W,
  parameter int FRAC        = NL_FRAC,
  parameter int NUM_NEURONS = 4,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic [DATA_W-1:0] data_in_4,
  input  logic [DATA_W-1:0] data_in_5,
  input  logic [DATA_W-1:0] data_in_6,
  input  logic              in_rdy,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_rd,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              in_drop
);

  localparam logic [3:0] K_LAST = 4'(NL_LAST_K);

  nl_state_e                        state_q, state_d;
  logic [3:0]                       k_q, k_d;
  logic [ADDR_W-1:0]                n_q, n_d;
  logic [NL_TERMS-1:0][DATA_W-1:0]  x_q;
  logic [DATA_W-1:0]                out_data_q;
  logic [ADDR_W-1:0]                out_idx_q;
  logic                             in_drop_q;

  logic              mac_clr, mac_acc, mac_bias;
  logic [DATA_W-1:0] mac_x, mac_res;
  logic              is_last;

  assign is_last = (n_q == ADDR_W'(NUM_NEURONS-1));

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    mac_clr  = 1'b0;
    mac_acc  = 1'b0;
    mac_bias = 1'b0;
    case (state_q)
      NL_IDLE: begin
        if (in_rdy) begin
          state_d = NL_RUN;
          k_d     = '0;
          n_d     = '0;
          mac_clr = 1'b1;
        end
      end
      NL_RUN: begin
        // w_data on this cycle answers the read issued for term k-1
        if (k_q != 4'd0) begin
          if (k_q == K_LAST) mac_bias = 1'b1;
          else               mac_acc  = 1'b1;
        end
        if (k_q == K_LAST) begin
          state_d = NL_OUT;
          k_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      NL_OUT: begin
        if (is_last) begin
          state_d = NL_IDLE;
        end else begin
          state_d = NL_RUN;
          n_d     = n_q + ADDR_W'(1);
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      default: state_d = NL_IDLE;
    endcase
  end

  // operand for term k-1; zero outside the weight terms
  always_comb begin
    mac_x = '0;
    for (int i = 0; i < NL_TERMS; i++)
      if (k_q == 4'(i+1)) mac_x = x_q[i];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= NL_IDLE;
      k_q        <= '0;
      n_q        <= '0;
      x_q        <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      in_drop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      in_drop_q <= in_rdy && (state_q != NL_IDLE);
      if (state_q == NL_IDLE && in_rdy)
        x_q <= {data_in_6, data_in_5, data_in_4, data_in_3, data_in_2, data_in_1, data_in_0};
      if (state_q == NL_OUT) begin
        out_data_q <= mac_res;
        out_idx_q  <= n_q;
      end
    end
  end

  neuron_mac #(.DATA_W(DATA_W), .FRAC(FRAC)) u_mac (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (mac_clr),
    .acc_i  (mac_acc),
    .bias_i (mac_bias),
    .w_i    (w_data),
    .x_i    (mac_x),
    .res_o  (mac_res)
  );

  assign w_rd      = (state_q == NL_RUN) && (k_q != K_LAST);
  assign w_addr    = w_rd ? ADDR_W'(int'(n_q) * NL_STRIDE + int'(k_q)) : '0;
  assign out_valid = (state_q == NL_OUT);
  assign out_last  = out_valid && is_last;
  // result is live during OUT, then held by the output registers
  assign out_data  = out_valid ? mac_res : out_data_q;
  assign out_idx   = out_valid ? n_q : out_idx_q;
  assign busy      = (state_q != NL_IDLE);
  assign in_drop   = in_drop_q;

endmodule
